// File: rtl/pred_rf_pkg.sv
// Shared types, default sizes and helpers for the per-warp predicate register file.
package pred_rf_pkg;

  localparam int unsigned PRED_NUM_LANES = 16;
  localparam int unsigned PRED_NUM_REGS  = 64;
  localparam int unsigned PRED_NUM_WARPS = 8;
  // Widest lane count the lane_mask helper handles.
  localparam int unsigned PRED_MAX_LANES = 64;

  typedef enum logic {
    CLR_IDLE = 1'b0,
    CLR_RUN  = 1'b1
  } clr_state_t;

  function automatic logic [PRED_MAX_LANES-1:0] lane_mask(
    input logic [PRED_MAX_LANES-1:0] read_en,
    input logic [PRED_MAX_LANES-1:0] data
  );
    return read_en & data;
  endfunction

endpackage

// File: rtl/pred_rf_clear_fsm.sv
// Sequenced warp clear: zeroes one predicate row per cycle of the latched warp.
module pred_rf_clear_fsm
  import pred_rf_pkg::*;
#(
  parameter  int unsigned NUM_REGS  = PRED_NUM_REGS,
  parameter  int unsigned NUM_WARPS = PRED_NUM_WARPS,
  localparam int unsigned RA_W      = $clog2(NUM_REGS),
  localparam int unsigned WS_W      = $clog2(NUM_WARPS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_clr_req,
  input  logic [WS_W-1:0] i_clr_warp,
  output logic            o_busy,
  output logic            o_done,
  output logic [WS_W-1:0] o_warp,
  output logic [RA_W-1:0] o_row_idx,
  output logic            o_row_zero_c,
  output logic            o_accept_c
);

  clr_state_t      r_state, w_state_nxt;
  logic [RA_W-1:0] r_row_cnt, w_row_nxt;
  logic [WS_W-1:0] r_warp, w_warp_nxt;
  logic            r_busy, r_done, w_done_nxt;

  // State and registered status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= CLR_IDLE;
      r_row_cnt <= '0;
      r_warp    <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_row_cnt <= w_row_nxt;
      r_warp    <= w_warp_nxt;
      r_busy    <= (w_state_nxt == CLR_RUN);
      r_done    <= w_done_nxt;
    end
  end

  // Next state; requests arriving while running are dropped
  always_comb begin
    w_state_nxt  = r_state;
    w_row_nxt    = r_row_cnt;
    w_warp_nxt   = r_warp;
    w_done_nxt   = 1'b0;
    o_row_zero_c = 1'b0;
    o_accept_c   = 1'b0;
    unique case (r_state)
      CLR_IDLE: begin
        if (i_clr_req) begin
          w_state_nxt = CLR_RUN;
          w_row_nxt   = '0;
          w_warp_nxt  = i_clr_warp;
          o_accept_c  = 1'b1;
        end
      end
      CLR_RUN: begin
        o_row_zero_c = 1'b1;
        if (r_row_cnt == RA_W'(NUM_REGS - 1)) begin
          w_state_nxt = CLR_IDLE;
          w_done_nxt  = 1'b1;
        end else begin
          w_row_nxt = r_row_cnt + RA_W'(1);
        end
      end
      default: w_state_nxt = CLR_IDLE;
    endcase
  end

  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_warp    = r_warp;
  assign o_row_idx = r_row_cnt;

endmodule

// File: rtl/pred_regfile_param.sv
// Per-warp predicate register file: two registered read ports, one write port, warp clear.
// Define PRED_BYPASS_EN to forward same-cycle write data to matching reads.
module pred_regfile_param
  import pred_rf_pkg::*;
#(
  parameter  int unsigned NUM_LANES = PRED_NUM_LANES,
  parameter  int unsigned NUM_REGS  = PRED_NUM_REGS,
  parameter  int unsigned NUM_WARPS = PRED_NUM_WARPS,
  localparam int unsigned RA_W      = $clog2(NUM_REGS),
  localparam int unsigned WS_W      = $clog2(NUM_WARPS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WS_W-1:0]      rd_warp,
  input  logic [NUM_LANES-1:0] read_en_0,
  input  logic [RA_W-1:0]      raddr_0,
  input  logic [NUM_LANES-1:0] read_en_1,
  input  logic [RA_W-1:0]      raddr_1,
  input  logic [WS_W-1:0]      wr_warp,
  input  logic [NUM_LANES-1:0] write_en,
  input  logic [RA_W-1:0]      waddr,
  input  logic [NUM_LANES-1:0] wdata,
  input  logic                 clr_req,
  input  logic [WS_W-1:0]      clr_warp,
  output logic [NUM_LANES-1:0] rdata_0,
  output logic                 rvalid_0,
  output logic [NUM_LANES-1:0] rdata_1,
  output logic                 rvalid_1,
  output logic                 clr_busy,
  output logic                 clr_done
);

  localparam bit REGS_POW2  = (NUM_REGS == (1 << RA_W));
  localparam bit WARPS_POW2 = (NUM_WARPS == (1 << WS_W));

  logic [NUM_LANES-1:0] r_mem [NUM_WARPS][NUM_REGS];
  logic [NUM_LANES-1:0] r_rdata [2];
  logic [1:0]           r_rvalid;

  logic [NUM_LANES-1:0] w_ren [2];
  logic [RA_W-1:0]      w_raddr [2];
  logic [NUM_LANES-1:0] w_row [2];
  logic [1:0]           w_raddr_ok;
  logic                 w_waddr_ok, w_rwarp_ok, w_wwarp_ok;
  logic                 w_clr_busy, w_clr_done, w_row_zero, w_clr_accept;
  logic [WS_W-1:0]      w_clr_warp;
  logic [RA_W-1:0]      w_clr_row;
  logic                 w_wr_drop, w_wr_go, w_rd_blk;

  assign w_ren[0]   = read_en_0;
  assign w_ren[1]   = read_en_1;
  assign w_raddr[0] = raddr_0;
  assign w_raddr[1] = raddr_1;

  pred_rf_clear_fsm #(
    .NUM_REGS  (NUM_REGS),
    .NUM_WARPS (NUM_WARPS)
  ) u_clear (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_clr_req    (clr_req),
    .i_clr_warp   (clr_warp),
    .o_busy       (w_clr_busy),
    .o_done       (w_clr_done),
    .o_warp       (w_clr_warp),
    .o_row_idx    (w_clr_row),
    .o_row_zero_c (w_row_zero),
    .o_accept_c   (w_clr_accept)
  );

  // Range checks only exist when the index space is not fully populated
  generate
    if (REGS_POW2) begin : g_regs_full
      assign w_raddr_ok = 2'b11;
      assign w_waddr_ok = 1'b1;
    end else begin : g_regs_part
      assign w_raddr_ok[0] = (raddr_0 < RA_W'(NUM_REGS));
      assign w_raddr_ok[1] = (raddr_1 < RA_W'(NUM_REGS));
      assign w_waddr_ok    = (waddr < RA_W'(NUM_REGS));
    end
    if (WARPS_POW2) begin : g_warps_full
      assign w_rwarp_ok = 1'b1;
      assign w_wwarp_ok = 1'b1;
    end else begin : g_warps_part
      assign w_rwarp_ok = (rd_warp < WS_W'(NUM_WARPS));
      assign w_wwarp_ok = (wr_warp < WS_W'(NUM_WARPS));
    end
  endgenerate

  // A warp being cleared, or about to be, takes no writes
  assign w_wr_drop = (w_clr_busy && (wr_warp == w_clr_warp)) ||
                     (w_clr_accept && (wr_warp == clr_warp));
  assign w_wr_go   = w_waddr_ok && w_wwarp_ok && !w_wr_drop;
  assign w_rd_blk  = w_clr_busy && (rd_warp == w_clr_warp);

  // Storage: clear strobe and lane-masked write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned w = 0; w < NUM_WARPS; w++) begin
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
          r_mem[w][r] <= '0;
        end
      end
    end else begin
      for (int unsigned w = 0; w < NUM_WARPS; w++) begin
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
          if (w_row_zero && (w_clr_warp == WS_W'(w)) && (w_clr_row == RA_W'(r))) begin
            r_mem[w][r] <= '0;
          end else if (w_wr_go && (wr_warp == WS_W'(w)) && (waddr == RA_W'(r))) begin
            r_mem[w][r] <= (r_mem[w][r] & ~write_en) | (wdata & write_en);
          end
        end
      end
    end
  end

  // Row selection per read port
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      w_row[p] = '0;
      if (w_rwarp_ok && w_raddr_ok[p]) begin
        w_row[p] = r_mem[rd_warp][w_raddr[p]];
      end
`ifdef PRED_BYPASS_EN
      if (w_wr_go && (wr_warp == rd_warp) && (waddr == w_raddr[p])) begin
        w_row[p] = (w_row[p] & ~write_en) | (wdata & write_en);
      end
`endif
      if (w_rd_blk) begin
        w_row[p] = '0;
      end
    end
  end

  // Read pipeline registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata[0] <= '0;
      r_rdata[1] <= '0;
      r_rvalid   <= '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        r_rvalid[p] <= |w_ren[p];
        r_rdata[p]  <= NUM_LANES'(lane_mask(PRED_MAX_LANES'(w_ren[p]),
                                            PRED_MAX_LANES'(w_row[p])));
      end
    end
  end

  assign rdata_0  = r_rdata[0];
  assign rdata_1  = r_rdata[1];
  assign rvalid_0 = r_rvalid[0];
  assign rvalid_1 = r_rvalid[1];
  assign clr_busy = w_clr_busy;
  assign clr_done = w_clr_done;

endmodule

// File: tb/tb_pred_regfile_param.sv
// Scoreboard bench for pred_regfile_param (default 16/64/8 plus a small 8/16/4 instance).
module tb_pred_regfile_param;

  logic        clk;
  logic        rst_n;
  logic [2:0]  rd_warp, wr_warp, clr_warp;
  logic [15:0] read_en_0, read_en_1, write_en, wdata;
  logic [5:0]  raddr_0, raddr_1, waddr;
  logic        clr_req;
  logic [15:0] rdata_0, rdata_1;
  logic        rvalid_0, rvalid_1, clr_busy, clr_done;

  logic [1:0]  s_rd_warp, s_wr_warp, s_clr_warp;
  logic [7:0]  s_read_en_0, s_read_en_1, s_write_en, s_wdata;
  logic [3:0]  s_raddr_0, s_raddr_1, s_waddr;
  logic        s_clr_req;
  logic [7:0]  s_rdata_0, s_rdata_1;
  logic        s_rvalid_0, s_rvalid_1, s_clr_busy, s_clr_done;

  int n_chk  = 0;
  int n_pass = 0;

  logic [15:0] m_mem [8][64];
  bit          pw_act;
  int          pw_w, pw_a;
  logic [15:0] pw_en, pw_d;

  string       sb_tag[$];
  logic [16:0] sb_e0[$];
  logic [16:0] sb_e1[$];
  logic [8:0]  sq0[$];
  logic [8:0]  sq1[$];

  pred_regfile_param u_dut (
    .clk(clk), .rst_n(rst_n), .rd_warp(rd_warp),
    .read_en_0(read_en_0), .raddr_0(raddr_0), .read_en_1(read_en_1), .raddr_1(raddr_1),
    .wr_warp(wr_warp), .write_en(write_en), .waddr(waddr), .wdata(wdata),
    .clr_req(clr_req), .clr_warp(clr_warp),
    .rdata_0(rdata_0), .rvalid_0(rvalid_0), .rdata_1(rdata_1), .rvalid_1(rvalid_1),
    .clr_busy(clr_busy), .clr_done(clr_done)
  );

  pred_regfile_param #(.NUM_LANES(8), .NUM_REGS(16), .NUM_WARPS(4)) u_small (
    .clk(clk), .rst_n(rst_n), .rd_warp(s_rd_warp),
    .read_en_0(s_read_en_0), .raddr_0(s_raddr_0), .read_en_1(s_read_en_1), .raddr_1(s_raddr_1),
    .wr_warp(s_wr_warp), .write_en(s_write_en), .waddr(s_waddr), .wdata(s_wdata),
    .clr_req(s_clr_req), .clr_warp(s_clr_warp),
    .rdata_0(s_rdata_0), .rvalid_0(s_rvalid_0), .rdata_1(s_rdata_1), .rvalid_1(s_rvalid_1),
    .clr_busy(s_clr_busy), .clr_done(s_clr_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Expected read value from the bench model, including forwarding when built in
  function automatic logic [15:0] mexp(input int w, input int a, input logic [15:0] en);
    logic [15:0] v;
    v = m_mem[w][a];
`ifdef PRED_BYPASS_EN
    if (pw_act && pw_w == w && pw_a == a) v = (v & ~pw_en) | (pw_d & pw_en);
`endif
    return v & en;
  endfunction

  task automatic wr(input int w, input int a, input logic [15:0] en, input logic [15:0] d,
                    input bit keep);
    wr_warp = 3'(w); waddr = 6'(a); write_en = en; wdata = d;
    pw_act = keep; pw_w = w; pw_a = a; pw_en = en; pw_d = d;
  endtask

  task automatic rd(input string tag, input int w, input int a0, input logic [15:0] en0,
                    input int a1, input logic [15:0] en1, input bit blk);
    rd_warp = 3'(w); raddr_0 = 6'(a0); raddr_1 = 6'(a1);
    read_en_0 = en0; read_en_1 = en1;
    sb_tag.push_back(tag);
    sb_e0.push_back({|en0, blk ? 16'h0 : mexp(w, a0, en0)});
    sb_e1.push_back({|en1, blk ? 16'h0 : mexp(w, a1, en1)});
  endtask

  task automatic tick();
    string       t;
    logic [16:0] e0, e1;
    @(posedge clk);
    if (pw_act) m_mem[pw_w][pw_a] = (m_mem[pw_w][pw_a] & ~pw_en) | (pw_d & pw_en);
    pw_act = 1'b0;
    #1;
    read_en_0 = '0; read_en_1 = '0; write_en = '0; clr_req = 1'b0;
    if (sb_tag.size() != 0) begin
      t  = sb_tag.pop_front();
      e0 = sb_e0.pop_front();
      e1 = sb_e1.pop_front();
      chk({t, "_p0"}, 32'({rvalid_0, rdata_0}), 32'(e0));
      chk({t, "_p1"}, 32'({rvalid_1, rdata_1}), 32'(e1));
    end else begin
      chk("idle_rvalid", 32'({rvalid_1, rvalid_0}), 32'd0);
    end
  endtask

  initial begin
    int n_busy;
    int cyc;
    logic [8:0] e;
    rst_n = 1'b0; pw_act = 1'b0;
    rd_warp = '0; wr_warp = '0; clr_warp = '0; read_en_0 = '0; read_en_1 = '0;
    write_en = '0; wdata = '0; raddr_0 = '0; raddr_1 = '0; waddr = '0; clr_req = 1'b0;
    s_rd_warp = '0; s_wr_warp = '0; s_clr_warp = '0; s_read_en_0 = '0; s_read_en_1 = '0;
    s_write_en = '0; s_wdata = '0; s_raddr_0 = '0; s_raddr_1 = '0; s_waddr = '0; s_clr_req = 1'b0;
    for (int w = 0; w < 8; w++) for (int r = 0; r < 64; r++) m_mem[w][r] = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_port0", 32'({rvalid_0, rdata_0}), 32'd0);
    chk("rst_port1", 32'({rvalid_1, rdata_1}), 32'd0);
    chk("rst_clr", 32'({clr_busy, clr_done}), 32'd0);
    chk("rst_small", 32'({s_rvalid_0, s_rvalid_1, s_clr_busy}), 32'd0);
    rst_n = 1'b1;

    // Reset contents of warps 0 and 7
    for (int w = 0; w < 8; w += 7) begin
      for (int r = 0; r < 64; r++) begin
        rd("rst_read", w, r, 16'hFFFF, 63 - r, 16'hFFFF, 1'b0);
        tick();
      end
    end

    // Full-row write, read back and neighbouring warp
    wr(3, 5, 16'hFFFF, 16'hFFFF, 1'b1); tick();
    rd("w3r5", 3, 5, 16'hFFFF, 5, 16'hFFFF, 1'b0); tick();
    rd("w2r5", 2, 5, 16'hFFFF, 5, 16'hFFFF, 1'b0); tick();

    // Partial lane mask
    wr(3, 6, 16'h00F0, 16'hFFFF, 1'b1); tick();
    rd("mask", 3, 6, 16'hFFFF, 6, 16'h0F0F, 1'b0); tick();

    // Same-cycle write and read
    wr(4, 9, 16'hFFFF, 16'hA5A5, 1'b1);
    rd("rw_same", 4, 9, 16'hFFFF, 9, 16'hFFFF, 1'b0); tick();
    rd("rw_after", 4, 9, 16'hFFFF, 9, 16'hFFFF, 1'b0); tick();
    wr(4, 10, 16'h00FF, 16'h3C3C, 1'b1);
    rd("rw_part", 4, 10, 16'hFFFF, 9, 16'h0FF0, 1'b0); tick();

    // Warp clear
    for (int w = 0; w < 2; w++) for (int r = 0; r < 64; r++) begin
      wr(w, r, 16'hFFFF, 16'hFFFF, 1'b1); tick();
    end
    clr_req = 1'b1; clr_warp = 3'd1; tick();
    n_busy = 0; cyc = 0;
    while (clr_busy && cyc < 200) begin
      n_busy++;
      if (cyc == 3) wr(1, 0, 16'hFFFF, 16'hFFFF, 1'b0);
      if (cyc == 5) begin clr_req = 1'b1; clr_warp = 3'd0; end
      if (cyc == 7) rd("clr_rd_w1", 1, 63, 16'hFFFF, 0, 16'h00FF, 1'b1);
      if (cyc == 9) rd("clr_rd_w0", 0, 3, 16'hFFFF, 40, 16'hFFFF, 1'b0);
      tick();
      cyc++;
    end
    chk("clr_busy_len", 32'(n_busy), 32'd64);
    chk("clr_done_hi", 32'(clr_done), 32'd1);
    tick();
    chk("clr_done_lo", 32'({clr_busy, clr_done}), 32'd0);
    for (int r = 0; r < 64; r++) m_mem[1][r] = '0;
    for (int r = 0; r < 64; r++) begin
      rd("post_clr", 1, r, 16'hFFFF, r, 16'hFFFF, 1'b0); tick();
      rd("post_w0", 0, r, 16'hFFFF, r, 16'hFFFF, 1'b0); tick();
    end
    chk("clr_ignored", 32'(clr_busy), 32'd0);

    // Walking-one sweep, default configuration
    for (int w = 0; w < 8; w++) for (int r = 0; r < 64; r++) begin
      wr(w, r, 16'hFFFF, 16'(1 << (r % 16)), 1'b1); tick();
    end
    for (int w = 0; w < 8; w++) for (int r = 0; r < 64; r++) begin
      rd("sweep", w, r, 16'hFFFF, (r + 1) % 64, 16'hFFFF, 1'b0); tick();
    end

    // Walking-one sweep, 8 lanes / 16 regs / 4 warps
    for (int w = 0; w < 4; w++) for (int r = 0; r < 16; r++) begin
      s_wr_warp = 2'(w); s_waddr = 4'(r); s_write_en = 8'hFF; s_wdata = 8'(1 << (r % 8));
      @(posedge clk); #1;
      s_write_en = '0;
    end
    for (int w = 0; w < 4; w++) for (int r = 0; r < 16; r++) begin
      s_rd_warp = 2'(w); s_raddr_0 = 4'(r); s_raddr_1 = 4'((r + 1) % 16);
      s_read_en_0 = 8'hFF; s_read_en_1 = 8'hFF;
      sq0.push_back({1'b1, 8'(1 << (r % 8))});
      sq1.push_back({1'b1, 8'(1 << ((r + 1) % 16 % 8))});
      @(posedge clk); #1;
      s_read_en_0 = '0; s_read_en_1 = '0;
      e = sq0.pop_front();
      chk("small_p0", 32'({s_rvalid_0, s_rdata_0}), 32'(e));
      e = sq1.pop_front();
      chk("small_p1", 32'({s_rvalid_1, s_rdata_1}), 32'(e));
    end
    chk("small_clr_idle", 32'({s_clr_busy, s_clr_done}), 32'd0);

    // Reset in the middle of a clear
    clr_req = 1'b1; clr_warp = 3'd2; tick();
    tick();
    chk("busy_pre_rst", 32'(clr_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("busy_in_rst", 32'({clr_busy, clr_done, rvalid_0, rvalid_1}), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(); tick();
    chk("busy_after_rst", 32'({clr_busy, clr_done}), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
